// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_unit: scoreboard hazard detection and forwarding control.
// Revision: 1.0
// ============================================================================
module pipeline_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          id_valid,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_mem_read,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic                          ex_redirect,
  output logic                          stall,
  output logic                          flush_if_id,
  output logic                          bubble_id_ex,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [15:0]                   stall_count
);

  // The entry FWD_DEPTH stages past EX can neither forward nor stall anyone
  // (the register file serves it), so only entries 0..FWD_DEPTH-1 are stored.
  localparam int NE = FWD_DEPTH;

  logic [NE-1:0]         sb_valid;
  logic [NE-1:0]         sb_wr;
  logic [LOAD_LAT-1:0]   sb_load;
  logic [REG_ADDR_W-1:0] sb_rd [NE];

  logic [NUM_SRC-1:0][NE-1:0] hit;
  logic                       load_use;
  logic                       advance;
  logic [NUM_SRC*SEL_W-1:0]   sel_next;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < NE; j++) begin
        hit[i][j] = id_valid && id_rs_used[i]
                    && (id_rs[i*REG_ADDR_W +: REG_ADDR_W] != '0)
                    && sb_valid[j] && sb_wr[j]
                    && (sb_rd[j] == id_rs[i*REG_ADDR_W +: REG_ADDR_W]);
      end
    end
  end

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < LOAD_LAT; j++) begin
        if (hit[i][j] && sb_load[j]) load_use = 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    sel_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (hit[i][k-1]) sel_next[i*SEL_W +: SEL_W] = SEL_W'(k);
      end
    end
  end

  assign stall        = load_use && !ex_redirect;
  assign flush_if_id  = enable && ex_redirect;
  assign bubble_id_ex = enable && (load_use || ex_redirect);
  assign advance      = !load_use && !ex_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid    <= '0;
      sb_wr       <= '0;
      sb_load     <= '0;
      for (int k = 0; k < NE; k++) sb_rd[k] <= '0;
      fwd_sel     <= '0;
      stall_count <= '0;
    end else if (enable) begin
      for (int k = 1; k < NE; k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_wr[k]    <= sb_wr[k-1];
        sb_rd[k]    <= sb_rd[k-1];
      end
      for (int k = 1; k < LOAD_LAT; k++) sb_load[k] <= sb_load[k-1];
      sb_valid[0] <= advance && id_valid;
      sb_wr[0]    <= advance && id_valid && id_reg_write;
      sb_load[0]  <= advance && id_valid && id_mem_read;
      sb_rd[0]    <= advance ? id_rd : '0;
      fwd_sel     <= advance ? sel_next : '0;
      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_unit: directed vector bench for pipeline_hazard_unit.
// Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_unit;

  logic       clk;
  logic       rst, enable, id_valid, id_reg_write, id_mem_read, ex_redirect;
  logic [4:0] id_rd;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;

  logic        stall, flush_if_id, bubble_id_ex;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_count;
  logic        stall3, flush3, bubble3;
  logic [3:0]  fwd3;
  logic [15:0] cnt3;

  int tests = 0;
  int fails = 0;

  pipeline_hazard_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .id_valid(id_valid), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .ex_redirect(ex_redirect), .stall(stall),
    .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex), .fwd_sel(fwd_sel),
    .stall_count(stall_count)
  );

  pipeline_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .id_valid(id_valid), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .ex_redirect(ex_redirect), .stall(stall3),
    .flush_if_id(flush3), .bubble_id_ex(bubble3), .fwd_sel(fwd3),
    .stall_count(cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst, en, v;
    logic [4:0]  rd;
    logic        wr, ld;
    logic [4:0]  rs0, rs1;
    logic [1:0]  used;
    logic        redir;
    logic        cc;
    logic        stall, flush, bubble;
    logic [1:0]  sel0, sel1;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(
      input logic r, input logic e, input logic v, input logic [4:0] rd,
      input logic wr, input logic ld, input logic [4:0] rs0, input logic [4:0] rs1,
      input logic [1:0] used, input logic redir, input logic cc,
      input logic st, input logic fl, input logic bu,
      input logic [1:0] s0, input logic [1:0] s1, input logic [15:0] cnt);
    vec_t t;
    t.rst = r; t.en = e; t.v = v; t.rd = rd; t.wr = wr; t.ld = ld;
    t.rs0 = rs0; t.rs1 = rs1; t.used = used; t.redir = redir; t.cc = cc;
    t.stall = st; t.flush = fl; t.bubble = bu; t.sel0 = s0; t.sel1 = s1; t.cnt = cnt;
    return t;
  endfunction

  task automatic drive(input logic r, input logic e, input logic v, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [1:0] used, input logic redir);
    rst = r; enable = e; id_valid = v; id_rd = rd; id_reg_write = wr;
    id_mem_read = ld; id_rs = {rs1, rs0}; id_rs_used = used; ex_redirect = redir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //          rst en v  rd wr ld rs0 rs1 used rdr cc  st fl bu s0 s1 cnt
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 1,  0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 5, 1, 0, 0,  0,  0,  0, 1,  0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 8, 1, 0, 5,  6,  3,  0, 1,  0, 0, 0, 1, 0, 0);
    vecs[4]  = mk(0, 1, 1, 7, 1, 1, 0,  0,  0,  0, 1,  0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 1,10, 1, 0, 7,  8,  3,  0, 1,  1, 0, 1, 0, 0, 1);
    vecs[6]  = mk(0, 1, 1,10, 1, 0, 7,  8,  3,  0, 1,  0, 0, 0, 2, 0, 1);
    vecs[7]  = mk(0, 1, 1, 3, 1, 0, 0,  0,  0,  0, 1,  0, 0, 0, 0, 0, 1);
    vecs[8]  = mk(0, 1, 1, 3, 1, 0, 0,  0,  0,  0, 1,  0, 0, 0, 0, 0, 1);
    vecs[9]  = mk(0, 1, 1,11, 1, 0, 3, 10,  3,  0, 1,  0, 0, 0, 1, 0, 1);
    vecs[10] = mk(0, 1, 1, 0, 1, 0, 0,  0,  0,  0, 1,  0, 0, 0, 0, 0, 1);
    vecs[11] = mk(0, 1, 1, 0, 1, 1, 0,  0,  0,  0, 1,  0, 0, 0, 0, 0, 1);
    vecs[12] = mk(0, 1, 1,12, 0, 0, 0,  0,  3,  0, 1,  0, 0, 0, 0, 0, 1);
    vecs[13] = mk(0, 1, 1, 7, 1, 1, 0,  0,  0,  0, 1,  0, 0, 0, 0, 0, 1);
    vecs[14] = mk(0, 1, 1,13, 1, 0, 7,  0,  1,  1, 1,  0, 1, 1, 0, 0, 1);
    vecs[15] = mk(0, 1, 1,14, 1, 0, 7, 13,  3,  0, 1,  0, 0, 0, 2, 0, 1);
    vecs[16] = mk(0, 1, 1, 9, 1, 1,14,  0,  1,  0, 1,  0, 0, 0, 1, 0, 1);
    vecs[17] = mk(0, 0, 1,15, 1, 0, 9, 14,  3,  0, 1,  1, 0, 0, 1, 0, 1);
    vecs[18] = mk(0, 0, 1,15, 1, 0, 9, 14,  3,  1, 1,  0, 0, 0, 1, 0, 1);
    vecs[19] = mk(0, 0, 1,15, 1, 0, 9, 14,  3,  0, 1,  1, 0, 0, 1, 0, 1);
    vecs[20] = mk(0, 1, 1,15, 1, 0, 9, 14,  3,  0, 1,  1, 0, 1, 0, 0, 2);
    vecs[21] = mk(0, 1, 1,15, 1, 0, 9, 14,  3,  0, 1,  0, 0, 0, 2, 0, 2);
    vecs[22] = mk(0, 1, 1, 4, 1, 1, 0,  0,  0,  0, 1,  0, 0, 0, 0, 0, 2);
    vecs[23] = mk(1, 1, 1,16, 1, 0, 4,  0,  1,  0, 1,  1, 0, 1, 0, 0, 0);
    vecs[24] = mk(0, 1, 1,16, 1, 0, 4,  0,  1,  0, 1,  0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].ld,
            vecs[i].rs0, vecs[i].rs1, vecs[i].used, vecs[i].redir);
      #2;
      if (vecs[i].cc) begin
        chk($sformatf("v%0d stall", i),  16'(stall),        16'(vecs[i].stall));
        chk($sformatf("v%0d flush", i),  16'(flush_if_id),  16'(vecs[i].flush));
        chk($sformatf("v%0d bubble", i), 16'(bubble_id_ex), 16'(vecs[i].bubble));
      end
      tick();
      chk($sformatf("v%0d sel0", i), 16'(fwd_sel[1:0]), 16'(vecs[i].sel0));
      chk($sformatf("v%0d sel1", i), 16'(fwd_sel[3:2]), 16'(vecs[i].sel1));
      chk($sformatf("v%0d cnt", i),  stall_count,       vecs[i].cnt);
    end

    // Deeper pipe: a LOAD_LAT=2 load-use costs two stalls, then forwards from stage 3.
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); #2; tick();
    drive(0, 1, 1, 9, 1, 1, 0, 0, 0, 0); #2; tick();
    drive(0, 1, 1, 16, 1, 0, 9, 0, 1, 0); #2;
    chk("d3 stall1", 16'(stall3), 16'd1);
    chk("d3 bubble1", 16'(bubble3), 16'd1);
    tick();
    chk("d3 sel after stall1", 16'(fwd3), 16'd0);
    chk("d3 cnt1", cnt3, 16'd1);
    #2;
    chk("d3 stall2", 16'(stall3), 16'd1);
    tick();
    chk("d3 cnt2", cnt3, 16'd2);
    #2;
    chk("d3 stall3 clear", 16'(stall3), 16'd0);
    chk("d3 bubble3 clear", 16'(bubble3), 16'd0);
    tick();
    chk("d3 sel0 fwd", 16'(fwd3[1:0]), 16'd3);
    chk("d3 cnt final", cnt3, 16'd2);

    // Reset landing on the first stall cycle clears everything.
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); #2; tick();
    drive(0, 1, 1, 9, 1, 1, 0, 0, 0, 0); #2; tick();
    drive(1, 1, 1, 16, 1, 0, 9, 0, 1, 0); #2;
    chk("d3 rst pre stall", 16'(stall3), 16'd1);
    tick();
    drive(0, 1, 1, 16, 1, 0, 9, 0, 1, 0); #2;
    chk("d3 rst stall", 16'(stall3), 16'd0);
    chk("d3 rst flush", 16'(flush3), 16'd0);
    chk("d3 rst bubble", 16'(bubble3), 16'd0);
    chk("d3 rst sel", 16'(fwd3), 16'd0);
    chk("d3 rst cnt", cnt3, 16'd0);
    tick();
    chk("d3 post rst sel", 16'(fwd3), 16'd0);
    chk("d3 post rst cnt", cnt3, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
